// File: rtl/roll_recorder.sv
// Settle detector and result history for the 4-bit LFSR roller.
// Commits a value once it holds steady for SETTLE_CYCLES and drives two active-low 7-seg digits.
module roll_recorder #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 2**26
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [3:0] i_random,
    input  logic       i_recall,
    output logic [6:0] o_hex1,
    output logic [6:0] o_hex0,
    output logic       o_rolling,
    output logic       o_commit,
    output logic [3:0] o_count,
    output logic [2:0] o_index
);

    localparam int unsigned     CNT_W    = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]      DEPTH_C  = 4'(DEPTH);
    localparam logic [6:0]      SEG_BLANK = 7'b1111111;
    localparam logic [6:0]      SEG_ONE   = 7'b1111001;

    typedef enum logic {S_IDLE, S_ROLL} state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_prev, w_prev_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_hist [DEPTH];
    logic [3:0]       w_hist_nxt [DEPTH];
    logic [3:0]       r_count, w_count_nxt;
    logic [2:0]       r_index, w_index_nxt;
    logic             r_commit, w_commit_nxt;
    logic [6:0]       r_hex1, w_hex1_nxt;
    logic [6:0]       r_hex0, w_hex0_nxt;
    logic             r_rolling;
    logic [3:0]       w_disp;
    logic             w_blank;

    // Units digit of v (0..15); the tens digit is handled separately.
    function automatic logic [6:0] f_units(input logic [3:0] v);
        case (v)
            4'd0, 4'd10: f_units = 7'b1000000;
            4'd1, 4'd11: f_units = 7'b1111001;
            4'd2, 4'd12: f_units = 7'b0100100;
            4'd3, 4'd13: f_units = 7'b0110000;
            4'd4, 4'd14: f_units = 7'b0011001;
            4'd5, 4'd15: f_units = 7'b0010010;
            4'd6:        f_units = 7'b0000010;
            4'd7:        f_units = 7'b1111000;
            4'd8:        f_units = 7'b0000000;
            4'd9:        f_units = 7'b0010000;
            default:     f_units = SEG_BLANK;
        endcase
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_prev    <= '0;
            r_cnt     <= '0;
            for (int k = 0; k < DEPTH; k++) r_hist[k] <= '0;
            r_count   <= '0;
            r_index   <= '0;
            r_commit  <= 1'b0;
            r_hex1    <= SEG_BLANK;
            r_hex0    <= SEG_BLANK;
            r_rolling <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= w_prev_nxt;
            r_cnt     <= w_cnt_nxt;
            for (int k = 0; k < DEPTH; k++) r_hist[k] <= w_hist_nxt[k];
            r_count   <= w_count_nxt;
            r_index   <= w_index_nxt;
            r_commit  <= w_commit_nxt;
            r_hex1    <= w_hex1_nxt;
            r_hex0    <= w_hex0_nxt;
            r_rolling <= (w_state_nxt == S_ROLL);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_prev_nxt   = r_prev;
        w_cnt_nxt    = r_cnt;
        for (int k = 0; k < DEPTH; k++) w_hist_nxt[k] = r_hist[k];
        w_count_nxt  = r_count;
        w_index_nxt  = r_index;
        w_commit_nxt = 1'b0;
        w_disp       = '0;
        w_blank      = 1'b0;

        // Start has priority over both commit and recall.
        if (i_start) begin
            w_state_nxt = S_ROLL;
            w_prev_nxt  = i_random;
            w_cnt_nxt   = '0;
        end else if (r_state == S_ROLL) begin
            if (i_random != r_prev) begin
                w_prev_nxt = i_random;
                w_cnt_nxt  = '0;
            end else if (r_cnt == CNT_LAST) begin
                for (int k = 1; k < DEPTH; k++) w_hist_nxt[k] = r_hist[k-1];
                w_hist_nxt[0] = i_random;
                if (r_count < DEPTH_C) w_count_nxt = r_count + 4'd1;
                w_index_nxt  = '0;
                w_state_nxt  = S_IDLE;
                w_commit_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end else if (i_recall && (r_count != 4'd0)) begin
            w_index_nxt = (({1'b0, r_index} + 4'd1) >= r_count) ? 3'd0 : r_index + 3'd1;
        end

        // Display follows the post-edge state so it updates with commit/recall.
        if (w_state_nxt == S_ROLL) begin
            w_disp = i_random;
        end else if (w_count_nxt == 4'd0) begin
            w_blank = 1'b1;
        end else begin
            for (int k = 0; k < DEPTH; k++)
                if (3'(k) == w_index_nxt) w_disp = w_hist_nxt[k];
        end

        w_hex1_nxt = (w_blank || (w_disp < 4'd10)) ? SEG_BLANK : SEG_ONE;
        w_hex0_nxt = w_blank ? SEG_BLANK : f_units(w_disp);
    end

    assign o_hex1    = r_hex1;
    assign o_hex0    = r_hex0;
    assign o_rolling = r_rolling;
    assign o_commit  = r_commit;
    assign o_count   = r_count;
    assign o_index   = r_index;

endmodule

// File: tb/tb_roll_recorder.sv
// Bench for roll_recorder: vector table, directed corner sequences, and random
// stimulus checked against a timestamp/queue reference model.
module tb_roll_recorder;

    localparam int unsigned S = 8;
    localparam int unsigned D = 4;
    localparam logic [6:0]  BL  = 7'b1111111;
    localparam logic [6:0]  ONE = 7'b1111001;
    localparam logic [6:0]  UNITS [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                           7'b0000000, 7'b0010000};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       recall = 1'b0;
    logic [3:0] rnd = 4'd0;
    logic [6:0] o_hex1, o_hex0;
    logic       o_rolling, o_commit;
    logic [3:0] o_count;
    logic [2:0] o_index;

    roll_recorder #(.DEPTH(D), .SETTLE_CYCLES(S)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_random(rnd), .i_recall(recall),
        .o_hex1(o_hex1), .o_hex0(o_hex0), .o_rolling(o_rolling), .o_commit(o_commit),
        .o_count(o_count), .o_index(o_index)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: roll state as a timestamp of the last change, history as a queue.
    logic [3:0] m_hist [$];
    bit         m_roll = 0;
    bit         m_commit = 0;
    logic [3:0] m_last = 0;
    int         m_tlast = 0;
    int         m_edge = 0;
    int         m_idx = 0;
    int         last_commit = -1;
    bit         commit_seen = 0;

    typedef struct {
        bit         s;
        logic [3:0] r;
        bit         c;
        logic [22:0] exp;
    } vec_t;

    function automatic logic [13:0] seg_of(input int v);
        return {(v >= 10) ? ONE : BL, UNITS[v % 10]};
    endfunction

    function automatic logic [22:0] model_out();
        logic [13:0] hex;
        if (m_roll)                 hex = seg_of(int'(m_last));
        else if (m_hist.size() == 0) hex = {BL, BL};
        else                        hex = seg_of(int'(m_hist[m_idx]));
        return {hex, m_roll, m_commit, 4'(m_hist.size()), 3'(m_idx)};
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_roll = 0; m_commit = 0; m_last = 0; m_idx = 0;
    endtask

    task automatic model_step(input bit s, input logic [3:0] r, input bit c);
        m_edge++;
        m_commit = 0;
        if (s) begin
            m_roll = 1; m_last = r; m_tlast = m_edge;
        end else if (m_roll) begin
            if (r != m_last) begin
                m_last = r; m_tlast = m_edge;
            end else if (m_edge - m_tlast == int'(S)) begin
                m_hist.push_front(r);
                if (m_hist.size() > int'(D)) void'(m_hist.pop_back());
                m_idx = 0; m_roll = 0; m_commit = 1;
            end
        end else if (c && m_hist.size() > 0) begin
            m_idx = (m_idx + 1) % m_hist.size();
        end
    endtask

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, m_edge, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [22:0] dut_out();
        return {o_hex1, o_hex0, o_rolling, o_commit, o_count, o_index};
    endfunction

    // One clock: drive, clock, step the model, then compare away from the edge.
    task automatic cycle(input bit s, input logic [3:0] r, input bit c, input string name);
        start = s; rnd = r; recall = c;
        @(posedge clk);
        model_step(s, r, c);
        #1;
        if (o_commit) begin
            last_commit = m_edge;
            commit_seen = 1;
        end
        check(name, dut_out(), model_out());
    endtask

    vec_t tbl [10];

    initial begin
        logic [3:0] cur;
        int e0;
        int exp_seq [4];

        // Roll to 13 held constant: commit on the 8th edge after start.
        tbl[0] = '{1'b1, 4'd13, 1'b0, {ONE, UNITS[3], 1'b1, 1'b0, 4'd0, 3'd0}};
        for (int i = 1; i < 8; i++)
            tbl[i] = '{1'b0, 4'd13, 1'b0, {ONE, UNITS[3], 1'b1, 1'b0, 4'd0, 3'd0}};
        tbl[8] = '{1'b0, 4'd13, 1'b0, {ONE, UNITS[3], 1'b0, 1'b1, 4'd1, 3'd0}};
        tbl[9] = '{1'b0, 4'd2,  1'b1, {ONE, UNITS[3], 1'b0, 1'b0, 4'd1, 3'd0}};

        repeat (2) @(negedge clk);
        check("reset_values", dut_out(), {BL, BL, 1'b0, 1'b0, 4'd0, 3'd0});
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 20; i++) cycle(1'b0, 4'($urandom_range(15)), 1'b0, "idle");
        check("idle_blank", dut_out(), {BL, BL, 1'b0, 1'b0, 4'd0, 3'd0});
        check_int("idle_no_commit", int'(commit_seen), 0);

        for (int i = 0; i < 10; i++) begin
            start = tbl[i].s; rnd = tbl[i].r; recall = tbl[i].c;
            @(posedge clk);
            model_step(tbl[i].s, tbl[i].r, tbl[i].c);
            #1;
            check($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
        end

        // Value changes 7->3 five edges in: commit lands 8 edges after the change.
        last_commit = -1;
        cycle(1'b1, 4'd7, 1'b0, "chg_start");
        e0 = m_edge;
        for (int i = 1; i < 5; i++) cycle(1'b0, 4'd7, 1'b0, "chg_hold7");
        for (int i = 5; i < 16; i++) cycle(1'b0, 4'd3, 1'b0, "chg_hold3");
        check_int("chg_commit_edge", last_commit - e0, 13);
        check_int("chg_digits", int'({o_hex1, o_hex0}), int'({BL, UNITS[3]}));

        // Five rolls saturate the history; recall walks newest to oldest and wraps.
        for (int v = 1; v <= 5; v++) begin
            cycle(1'b1, 4'(v), 1'b0, "five_start");
            for (int i = 0; i < 8; i++) cycle(1'b0, 4'(v), 1'b0, "five_hold");
        end
        check_int("five_count", int'(o_count), 4);
        check_int("five_newest", int'(o_hex0), int'(UNITS[5]));
        exp_seq = '{4, 3, 2, 5};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 4'd0, 1'b1, "recall");
            check_int($sformatf("recall_digit[%0d]", i), int'(o_hex0), int'(UNITS[exp_seq[i]]));
        end
        check_int("recall_wrap_index", int'(o_index), 0);

        // Start with recall in the same cycle, then a re-arming start mid-roll.
        cycle(1'b0, 4'd0, 1'b1, "pre_recall");
        last_commit = -1;
        cycle(1'b1, 4'd9, 1'b1, "start_recall");
        e0 = m_edge;
        check_int("start_recall_index", int'(o_index), 1);
        check_int("start_recall_roll", int'(o_rolling), 1);
        for (int i = 1; i < 6; i++) cycle(1'b0, 4'd9, 1'b0, "rearm_hold");
        cycle(1'b1, 4'd9, 1'b0, "rearm_start");
        for (int i = 7; i < 17; i++) cycle(1'b0, 4'd9, 1'b0, "rearm_hold2");
        check_int("rearm_commit_edge", last_commit - e0, 14);

        // Reset mid-roll clears everything and nothing is committed.
        cycle(1'b1, 4'd6, 1'b0, "mid_start");
        for (int i = 1; i < 4; i++) cycle(1'b0, 4'd6, 1'b0, "mid_hold");
        rst_n = 1'b0;
        #2;
        check("mid_reset_values", dut_out(), {BL, BL, 1'b0, 1'b0, 4'd0, 3'd0});
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        commit_seen = 0;
        for (int i = 0; i < 20; i++) cycle(1'b0, 4'd6, 1'b0, "post_reset");
        check_int("post_reset_no_commit", int'(commit_seen), 0);

        // Random stimulus against the model.
        cur = 4'($urandom_range(15));
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(11) == 0) cur = 4'($urandom_range(15));
            cycle(($urandom_range(39) == 0), cur, ($urandom_range(3) == 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
